aes_cipher_iter: RTL and testbench

Iterative AES forward cipher (encryption), the counterpart of the team's unrolled inverse cipher. It computes one round per clock over a single registered state, using the aes_const parameters Nb and Nr. The block takes plaintext and a pre-expanded key schedule and returns ciphertext through valid/ready handshakes on both sides. It sits next to the decrypt path in the top level, shares the expanded key KExp with it, and uses the forward S-box table SBox.

---
 rtl/aes_cipher_iter.sv | 115 +++++++++++
 tb/tb_aes_cipher_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 forward cipher: one round per clock over a single registered state.
// Plaintext and ciphertext use valid/ready handshakes; the expanded key is read every round.
module aes_cipher_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SBox     [0:255],
  input  logic [31:0] KExp     [0:43],
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Data_in  [0:15],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Data_out [0:15],
  output logic        busy
);

  localparam int unsigned NB = 4;
  localparam int unsigned NR = 10;
  localparam int unsigned NBYTES = 4 * NB;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_rnd, w_rnd_nxt;
  logic [7:0]  r_st     [0:NBYTES-1];
  logic [7:0]  w_st_nxt [0:NBYTES-1];
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_busy, w_busy_nxt;

  logic [7:0]  w_sb  [0:NBYTES-1];
  logic [7:0]  w_sr  [0:NBYTES-1];
  logic [7:0]  w_mc  [0:NBYTES-1];
  logic [7:0]  w_rk  [0:NBYTES-1];
  logic [7:0]  w_k0  [0:NBYTES-1];
  logic [5:0]  w_kbase;
  logic        w_accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_kbase  = {r_rnd, 2'b00};
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Round datapath: SubBytes, ShiftRows, MixColumns and the round-key bytes
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sb[4*c+r] = SBox[r_st[4*c+r]];
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
      assign w_rk[4*c+r] = KExp[w_kbase + 6'(c)][8*(3-r) +: 8];
      assign w_k0[4*c+r] = KExp[c][8*(3-r) +: 8];
    end
    assign w_mc[4*c+0] = xt(w_sr[4*c+0]) ^ xt(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c+0] ^ xt(w_sr[4*c+1]) ^ xt(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xt(w_sr[4*c+2]) ^ xt(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xt(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xt(w_sr[4*c+3]);
  end

  // Ciphertext is only exposed while a result is pending
  for (genvar i = 0; i < NBYTES; i++) begin : g_out
    assign Data_out[i] = r_out_valid ? r_st[i] : 8'h00;
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    for (int i = 0; i < NBYTES; i++) w_st_nxt[i] = r_st[i];

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          for (int i = 0; i < NBYTES; i++) w_st_nxt[i] = Data_in[i] ^ w_k0[i];
          w_rnd_nxt   = 4'd1;
          w_state_nxt = S_RUN;
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_rnd == 4'(NR)) begin
          for (int i = 0; i < NBYTES; i++) w_st_nxt[i] = w_sr[i] ^ w_rk[i];
          w_state_nxt = S_DONE;
        end else begin
          for (int i = 0; i < NBYTES; i++) w_st_nxt[i] = w_mc[i] ^ w_rk[i];
          w_rnd_nxt = r_rnd + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rnd       <= 4'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < NBYTES; i++) r_st[i] <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_rnd       <= w_rnd_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      for (int i = 0; i < NBYTES; i++) r_st[i] <= w_st_nxt[i];
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter against published AES-128 vectors.
// The S-box and key schedule are generated here from the AES field definitions.
module tb_aes_cipher_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sbox [0:255];
  logic [31:0] kexp [0:43];
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  din  [0:15];
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dout [0:15];
  logic        busy;

  int errs   = 0;
  int checks = 0;
  logic run_bad;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [0:2];

  always #5 clk = ~clk;

  aes_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
    .SBox      (sbox),
    .KExp      (kexp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Data_in   (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data_out  (dout),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic gen_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox[a] = s;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) kexp[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = kexp[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      kexp[i] = kexp[i-4] ^ t;
    end
  endtask

  task automatic set_pt(input logic [127:0] pt);
    for (int i = 0; i < 16; i++) din[i] = pt[127-8*i -: 8];
  endtask

  function automatic logic [127:0] get_out();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = dout[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance until out_valid; run_bad flags any RUN cycle without busy=1/in_ready=0
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) run_bad = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    set_key(v.key);
    set_pt(v.pt);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    set_pt(~v.pt);
    run_bad = 1'b0;
    wait_out(n);
    chk({nm, " latency"}, 128'(n), 128'd10);
    chk({nm, " run flags"}, 128'(run_bad), 128'd0);
    chk({nm, " ct"}, get_out(), v.ct);
    chk({nm, " in_ready in done"}, 128'(in_ready), 128'd1);
    tick();
    chk({nm, " out_valid drop"}, 128'(out_valid), 128'd0);
    chk({nm, " data_out zero"}, get_out(), 128'd0);
  endtask

  initial begin
    int  n;
    int  n2;
    logic hold_bad;
    logic spur;

    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_pt(128'h0);
    gen_sbox();
    set_key(128'h0);
    tick();
    tick();
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset data_out", get_out(), 128'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 3; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: result held while out_ready is low
    set_key(vecs[0].key);
    set_pt(vecs[0].pt);
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    hold_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || get_out() !== vecs[0].ct)
        hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp hold", 128'(hold_bad), 128'd0);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready on release", 128'(in_ready), 128'd1);
    tick();
    chk("bp out_valid drop", 128'(out_valid), 128'd0);
    chk("bp in_ready idle", 128'(in_ready), 128'd1);

    // Back-to-back: second block accepted on the output handshake edge
    set_key(vecs[0].key);
    set_pt(vecs[0].pt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("b2b first ct", get_out(), vecs[0].ct);
    set_key(vecs[1].key);
    set_pt(vecs[1].pt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b2b no bubble busy", 128'(busy), 128'd1);
    wait_out(n2);
    chk("b2b spacing", 128'(n2 + 1), 128'd11);
    chk("b2b second ct", get_out(), vecs[1].ct);
    tick();

    // Reset mid-run, with in_valid high at the reset edge
    set_key(vecs[1].key);
    set_pt(vecs[1].pt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst in_ready", 128'(in_ready), 128'd1);
    chk("midrst out_valid", 128'(out_valid), 128'd0);
    chk("midrst busy", 128'(busy), 128'd0);
    spur = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) spur = 1'b1;
    end
    chk("midrst no spurious output", 128'(spur), 128'd0);
    run_vec(vecs[0], "after rst");

    // Data_in changed and in_valid pulsed during RUN
    set_key(vecs[0].key);
    set_pt(vecs[0].pt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    run_bad = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    set_pt(vecs[1].pt);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("poke latency", 128'(n + 5), 128'd10);
    chk("poke ct", get_out(), vecs[0].ct);
    tick();
    chk("poke out_valid drop", 128'(out_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
